// File: rtl/fb_scanout.sv
// fb_scanout
// Framebuffer scan-out stage. It turns the live raster position into read
// addresses for a double-buffered, down-scaled framebuffer BRAM. It realigns
// hsync/vsync and the visible flag to the BRAM read latency, and it drives
// blanked RGB. It also owns front/back buffer selection: swap requests that
// arrive from the draw clock domain take effect only at end-of-frame.
//
// Ports:
//   pix_clk, rst_n         pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt           raster position from the timing counters
//   h_visible, v_visible   active-area flags for h_cnt / v_cnt
//   hsync_in, vsync_in     undelayed active-low syncs
//   eof                    one-cycle end-of-frame pulse
//   swap_toggle            toggle-encoded swap request (draw domain, async)
//   rd_en, rd_addr         BRAM read enable / pixel address within buffer
//   rd_buf_sel             buffer being scanned (BRAM address MSB)
//   rd_data                BRAM read data, RD_LAT cycles after rd_addr
//   vga_rgb                blanked RGB444 pixel {R, G, B}
//   vga_hsync, vga_vsync   syncs delayed to line up with vga_rgb
//   front_buf              current front buffer index
//   swap_ack_toggle        flips once per applied swap
module fb_scanout #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15,
   parameter int PIX_W       = 12,
   parameter int RD_LAT      = 2
) (
   input  logic              pix_clk,
   input  logic              rst_n,
   input  logic [9:0]        h_cnt,
   input  logic [9:0]        v_cnt,
   input  logic              h_visible,
   input  logic              v_visible,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              eof,
   input  logic              swap_toggle,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_buf_sel,
   input  logic [PIX_W-1:0]  rd_data,
   output logic [PIX_W-1:0]  vga_rgb,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic              front_buf,
   output logic              swap_ack_toggle
);

   localparam int LAT   = RD_LAT + 2;
   localparam int ROW_W = H_ACTIVE >> SCALE_SHIFT;

   logic              vis_p0;
   logic              row_end_p0;
   logic [ADDR_W-1:0] col_p0;
   logic [ADDR_W-1:0] row_base;
   logic [RD_LAT-1:0] vld_pipe;
   logic [LAT-1:0]    hs_pipe;
   logic [LAT-1:0]    vs_pipe;
   logic              swap_meta;
   logic              swap_sync;
   logic              swap_last;
   logic              swap_pending;
   logic              swap_edge;
   logic              unused_bits;

   // Only the low v_cnt bits select the last replicated line of a framebuffer
   // row; the vertical bound itself arrives already decoded as v_visible.
   assign unused_bits = ^{v_cnt[9:SCALE_SHIFT], V_ACTIVE[0]};

   // ---- stage p0: raster position -> framebuffer address ----
   assign vis_p0     = h_visible & v_visible;
   assign col_p0     = ADDR_W'(h_cnt >> SCALE_SHIFT);
   assign row_end_p0 = v_visible && (h_cnt == 10'(H_ACTIVE)) && (&v_cnt[SCALE_SHIFT-1:0]);

   // row_base replaces a v*ROW_W multiply: it steps one framebuffer row
   // after the last of each group of replicated screen lines.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         row_base <= '0;
      end else if (!v_visible) begin
         row_base <= '0;
      end else if (row_end_p0) begin
         row_base <= row_base + ADDR_W'(ROW_W);
      end
   end

   // ---- stage p1: registered BRAM request ----
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
      end else begin
         rd_en   <= vis_p0;
         rd_addr <= vis_p0 ? (row_base + col_p0) : '0;
      end
   end

   // ---- stages p2..p(1+RD_LAT): visible flag follows the BRAM read ----
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // ---- output stage: blanked RGB ----
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_rgb <= '0;
      end else begin
         vga_rgb <= vld_pipe[RD_LAT-1] ? rd_data : '0;
      end
   end

   // Sync delay line spans the full request + read + output latency;
   // it resets to the inactive (high) level.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_pipe <= '1;
         vs_pipe <= '1;
      end else begin
         hs_pipe <= {hs_pipe[LAT-2:0], hsync_in};
         vs_pipe <= {vs_pipe[LAT-2:0], vsync_in};
      end
   end

   assign vga_hsync = hs_pipe[LAT-1];
   assign vga_vsync = vs_pipe[LAT-1];

   // Swap request crossing: 2-flop synchronizer, then an XOR edge detect
   // against the last synchronized value. An edge that coincides with eof
   // is applied immediately; otherwise it waits in swap_pending. Further
   // edges while pending coalesce into the same swap.
   assign swap_edge = swap_sync ^ swap_last;

   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         swap_meta       <= 1'b0;
         swap_sync       <= 1'b0;
         swap_last       <= 1'b0;
         swap_pending    <= 1'b0;
         front_buf       <= 1'b0;
         swap_ack_toggle <= 1'b0;
      end else begin
         swap_meta <= swap_toggle;
         swap_sync <= swap_meta;
         swap_last <= swap_sync;
         if (eof && (swap_pending || swap_edge)) begin
            front_buf       <= ~front_buf;
            swap_ack_toggle <= ~swap_ack_toggle;
            swap_pending    <= 1'b0;
         end else if (swap_edge) begin
            swap_pending <= 1'b1;
         end
      end
   end

   assign rd_buf_sel = front_buf;

endmodule
